// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, condition ifuns, status codes and
// the pipeline-register bubble constants.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] BUBBLE_STAT  = S_AOK;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic       BUBBLE_CND   = 1'b0;

endpackage

// File: rtl/exec_cc_mreg_if.sv
// Execute-stage inputs and E->M register outputs; the DUT takes the slave side.
interface exec_cc_mreg_if #(parameter int WIDTH = 64);
  logic [3:0]       e_stat, e_icode, e_ifun;
  logic [WIDTH-1:0] e_valE, e_valA;
  logic             e_zf, e_sf, e_of;
  logic [3:0]       e_dstE, e_dstM;
  logic             m_exc, w_exc, M_bubble, M_stall;

  logic             e_Cnd;
  logic [3:0]       e_dstE_out;
  logic             cc_zf, cc_sf, cc_of;
  logic [3:0]       M_stat, M_icode;
  logic             M_Cnd;
  logic [WIDTH-1:0] M_valE, M_valA;
  logic [3:0]       M_dstE, M_dstM;

  modport master (
    output e_stat, e_icode, e_ifun, e_valE, e_valA, e_zf, e_sf, e_of,
           e_dstE, e_dstM, m_exc, w_exc, M_bubble, M_stall,
    input  e_Cnd, e_dstE_out, cc_zf, cc_sf, cc_of,
           M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  e_stat, e_icode, e_ifun, e_valE, e_valA, e_zf, e_sf, e_of,
           e_dstE, e_dstM, m_exc, w_exc, M_bubble, M_stall,
    output e_Cnd, e_dstE_out, cc_zf, cc_sf, cc_of,
           M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/exec_cc_mreg_cond_eval.sv
// Branch/cmov condition from {ZF,SF,OF}; also used by the fetch-side predictor check.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] i_ifun,
  input  logic       i_zf,
  input  logic       i_sf,
  input  logic       i_of,
  output logic       o_cnd
);
  logic w_lt;
  assign w_lt = i_sf ^ i_of;

  always_comb begin
    o_cnd = 1'b0;
    case (i_ifun)
      C_YES:   o_cnd = 1'b1;
      C_LE:    o_cnd = w_lt | i_zf;
      C_L:     o_cnd = w_lt;
      C_E:     o_cnd = i_zf;
      C_NE:    o_cnd = ~i_zf;
      C_GE:    o_cnd = ~w_lt;
      C_G:     o_cnd = ~w_lt & ~i_zf;
      default: o_cnd = 1'b0;
    endcase
  end
endmodule

// File: rtl/exec_cc_mreg.sv
// Y86-64 condition-code register, Cnd evaluation and the E->M pipeline register
// with hazard-unit bubble/stall control.
module exec_cc_mreg
  import y86_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  exec_cc_mreg_if.slave     bus
);
  logic [2:0]       r_cc;
  logic [3:0]       r_m_stat, r_m_icode, r_m_dstE, r_m_dstM;
  logic             r_m_cnd;
  logic [WIDTH-1:0] r_m_valE, r_m_valA;

  logic       w_cond, w_cnd, w_set_cc;
  logic [3:0] w_dstE;

  // Cnd sees the CC value before this cycle's OPq updates it.
  cond_eval u_cond (
    .i_ifun (bus.e_ifun),
    .i_zf   (r_cc[2]),
    .i_sf   (r_cc[1]),
    .i_of   (r_cc[0]),
    .o_cnd  (w_cond)
  );

  assign w_cnd    = ((bus.e_icode == I_CMOV) || (bus.e_icode == I_JXX)) & w_cond;
  assign w_dstE   = ((bus.e_icode == I_CMOV) && !w_cnd) ? RNONE : bus.e_dstE;
  assign w_set_cc = (bus.e_icode == I_OPQ) & ~bus.m_exc & ~bus.w_exc & (bus.e_stat == S_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cc <= CC_RESET;
    else if (w_set_cc) r_cc <= {bus.e_zf, bus.e_sf, bus.e_of};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.M_bubble) begin
      r_m_stat  <= BUBBLE_STAT;
      r_m_icode <= BUBBLE_ICODE;
      r_m_cnd   <= BUBBLE_CND;
      r_m_valE  <= '0;
      r_m_valA  <= '0;
      r_m_dstE  <= RNONE;
      r_m_dstM  <= RNONE;
    end else if (!bus.M_stall) begin
      r_m_stat  <= bus.e_stat;
      r_m_icode <= bus.e_icode;
      r_m_cnd   <= w_cnd;
      r_m_valE  <= bus.e_valE;
      r_m_valA  <= bus.e_valA;
      r_m_dstE  <= w_dstE;
      r_m_dstM  <= bus.e_dstM;
    end
  end

  assign bus.e_Cnd      = w_cnd;
  assign bus.e_dstE_out = w_dstE;
  assign bus.cc_zf      = r_cc[2];
  assign bus.cc_sf      = r_cc[1];
  assign bus.cc_of      = r_cc[0];
  assign bus.M_stat     = r_m_stat;
  assign bus.M_icode    = r_m_icode;
  assign bus.M_Cnd      = r_m_cnd;
  assign bus.M_valE     = r_m_valE;
  assign bus.M_valA     = r_m_valA;
  assign bus.M_dstE     = r_m_dstE;
  assign bus.M_dstM     = r_m_dstM;
endmodule

// File: tb/tb_exec_cc_mreg.sv
// Scoreboard bench for exec_cc_mreg: directed hazard cases plus random traffic.
module tb_exec_cc_mreg;
  logic clk, rst;
  int checks = 0;
  int failures = 0;

  exec_cc_mreg_if #(.WIDTH(64)) bus ();
  exec_cc_mreg #(.WIDTH(64), .CC_RESET(3'b100)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stat, icode;
    logic        cnd;
    logic [63:0] valE, valA;
    logic [3:0]  dstE, dstM;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];
  exp_t mdl_m;
  logic [2:0] mdl_cc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t bubble_val();
    exp_t b;
    b.stat = 4'h1; b.icode = 4'h1; b.cnd = 1'b0; b.valE = '0; b.valA = '0;
    b.dstE = 4'hF; b.dstM = 4'hF; b.cc = 3'b000;
    return b;
  endfunction

  // Branch semantics in terms of signed comparison outcomes.
  function automatic logic mcond(input logic [3:0] f, input logic [2:0] cc);
    logic zero, less;
    zero = cc[2];
    less = (cc[1] != cc[0]);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || zero;
      4'd2: return less;
      4'd3: return zero;
      4'd4: return !zero;
      4'd5: return !less;
      4'd6: return !less && !zero;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    mdl_cc = 3'b100;
    mdl_m  = bubble_val();
  endtask

  task automatic step(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] valE, input logic [63:0] valA, input logic [2:0] flags,
                      input logic [3:0] dstE, input logic [3:0] dstM,
                      input logic mexc, input logic wexc, input logic bub, input logic stl);
    logic ecnd;
    logic [3:0] edst;
    exp_t e;
    bus.e_stat = stat; bus.e_icode = icode; bus.e_ifun = ifun;
    bus.e_valE = valE; bus.e_valA = valA;
    {bus.e_zf, bus.e_sf, bus.e_of} = flags;
    bus.e_dstE = dstE; bus.e_dstM = dstM;
    bus.m_exc = mexc; bus.w_exc = wexc; bus.M_bubble = bub; bus.M_stall = stl;
    #1;
    ecnd = (icode == 4'd2 || icode == 4'd7) ? mcond(ifun, mdl_cc) : 1'b0;
    edst = (icode == 4'd2 && !ecnd) ? 4'hF : dstE;
    chk("e_Cnd", {63'd0, bus.e_Cnd}, {63'd0, ecnd});
    chk("e_dstE_out", {60'd0, bus.e_dstE_out}, {60'd0, edst});
    if (icode == 4'd6 && !mexc && !wexc && stat == 4'd1) mdl_cc = flags;
    if (bub) mdl_m = bubble_val();
    else if (!stl) begin
      mdl_m.stat = stat; mdl_m.icode = icode; mdl_m.cnd = ecnd;
      mdl_m.valE = valE; mdl_m.valA = valA; mdl_m.dstE = edst; mdl_m.dstM = dstM;
    end
    e = mdl_m;
    e.cc = mdl_cc;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".cc"}, {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of}, {61'd0, e.cc});
    chk({tag, ".M_stat"}, {60'd0, bus.M_stat}, {60'd0, e.stat});
    chk({tag, ".M_icode"}, {60'd0, bus.M_icode}, {60'd0, e.icode});
    chk({tag, ".M_Cnd"}, {63'd0, bus.M_Cnd}, {63'd0, e.cnd});
    chk({tag, ".M_valE"}, bus.M_valE, e.valE);
    chk({tag, ".M_valA"}, bus.M_valA, e.valA);
    chk({tag, ".M_dstE"}, {60'd0, bus.M_dstE}, {60'd0, e.dstE});
    chk({tag, ".M_dstM"}, {60'd0, bus.M_dstM}, {60'd0, e.dstM});
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) chk_outputs("mon", q.pop_front());
  end

  task automatic async_reset_check(input string tag);
    exp_t r;
    rst = 1'b1;
    #1;
    r = bubble_val();
    r.cc = 3'b100;
    chk_outputs(tag, r);
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ic, fn, st;
    int wait_cyc;
    rst = 1'b0;
    bus.e_stat = 4'h1; bus.e_icode = 4'h1; bus.e_ifun = 4'h0;
    bus.e_valE = '0; bus.e_valA = '0; bus.e_zf = 0; bus.e_sf = 0; bus.e_of = 0;
    bus.e_dstE = 4'hF; bus.e_dstM = 4'hF;
    bus.m_exc = 0; bus.w_exc = 0; bus.M_bubble = 0; bus.M_stall = 0;
    #2;
    async_reset_check("rst0");

    // CC 000 then OPq sub giving zero -> CC 100; jle taken
    step(1, 6, 1, 64'h5, 0, 3'b000, 4'h3, 4'hF, 0, 0, 0, 0);
    step(1, 6, 1, 64'h0, 0, 3'b100, 4'h3, 4'hF, 0, 0, 0, 0);
    step(1, 7, 1, 64'h0, 64'h400, 3'b000, 4'hF, 4'hF, 0, 0, 0, 0);
    // cmovne taken with CC 000, untaken with CC 100
    step(1, 6, 0, 64'h7, 0, 3'b000, 4'h2, 4'hF, 0, 0, 0, 0);
    step(1, 2, 4, 64'h11, 64'h11, 3'b000, 4'h3, 4'hF, 0, 0, 0, 0);
    step(1, 6, 1, 64'h0, 0, 3'b100, 4'h2, 4'hF, 0, 0, 0, 0);
    step(1, 2, 4, 64'h22, 64'h22, 3'b000, 4'h3, 4'hF, 0, 0, 0, 0);
    // exception downstream blocks CC update but M still loads
    step(1, 6, 0, 64'hDEAD_BEEF_0000_0001, 0, 3'b010, 4'h4, 4'hF, 1, 0, 0, 0);
    step(1, 6, 0, 64'h1234, 0, 3'b001, 4'h4, 4'hF, 0, 1, 0, 0);
    step(3, 6, 0, 64'h1234, 0, 3'b001, 4'h4, 4'hF, 0, 0, 0, 0);
    // bubble, bubble+stall, stall hold
    step(1, 5, 0, 64'h100, 64'h0, 3'b000, 4'hF, 4'h5, 0, 0, 1, 0);
    step(1, 5, 0, 64'h108, 64'h0, 3'b000, 4'hF, 4'h6, 0, 0, 1, 1);
    step(1, 3, 0, 64'hABCD, 64'h0, 3'b000, 4'h7, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 4'(4 + i), 0, 64'(i * 17 + 3), 64'(i), 3'b000, 4'(i), 4'(i + 8), 0, 0, 0, 1);
    // jg untaken with CC 010, jXX ifun 9, irmovq passes dstE
    step(1, 6, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b010, 4'h1, 4'hF, 0, 0, 0, 0);
    step(1, 7, 6, 0, 64'h40, 3'b000, 4'hF, 4'hF, 0, 0, 0, 0);
    step(1, 7, 9, 0, 64'h40, 3'b000, 4'hF, 4'hF, 0, 0, 0, 0);
    step(1, 3, 0, 64'h99, 0, 3'b000, 4'h6, 4'hF, 0, 0, 0, 0);
    // mid-stream asynchronous reset with non-reset state
    step(1, 6, 0, 64'h77, 64'h66, 3'b011, 4'h2, 4'h3, 0, 0, 0, 0);
    #2;
    async_reset_check("rst_mid");

    for (int n = 0; n < 400; n++) begin
      ic = 4'($urandom_range(0, 11));
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      st = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
      step(st, ic, fn, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exec_cc_mreg.md
Name: exec_cc_mreg

Overview:
- Downstream consumer of the 64-bit execute-stage ALU in the 5-stage pipelined Y86-64 core.
- Holds the architectural condition-code register (ZF/SF/OF) and evaluates the branch/cmov condition (Cnd) from it.
- Latches the execute-stage results into the E->M pipeline register, with bubble and stall control from the hazard unit.

Parameters:
- WIDTH, 64, datapath word width.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- e_stat  in  4  status of the instruction in execute (AOK=1, HLT=2, ADR=3, INS=4).
- e_icode  in  4  icode in execute.
- e_ifun  in  4  ifun in execute.
- e_valE  in  WIDTH  ALU result.
- e_zf / e_sf / e_of  in  1 each  ALU flags for the current operation.
- e_valA  in  WIDTH  forwarded valA.
- e_dstE / e_dstM  in  4  destination register IDs (4'hF = RNONE).
- m_exc  in  1  instruction in memory stage has stat in {ADR,INS,HLT}.
- w_exc  in  1  instruction in writeback has stat in {ADR,INS,HLT}.
- M_bubble  in  1  load a bubble into M.
- M_stall  in  1  hold M.
- e_Cnd  out  1  combinational condition result.
- e_dstE_out  out  4  e_dstE, or RNONE for an untaken cmov.
- cc_zf / cc_sf / cc_of  out  1 each  registered CC.
- M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  out  4/4/1/WIDTH/WIDTH/4/4  E->M register.

Behaviour:
- Reset (async, any time, including mid-stream):
  - {cc_zf,cc_sf,cc_of} = CC_RESET.
  - M register = bubble: stat=1, icode=1 (nop), Cnd=0, valE=0, valA=0, dstE=dstM=4'hF.
- Release is synchronous to the next clk rising edge.
- Cnd is combinational from the registered CC, evaluated before this cycle's update:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF)&~ZF.
  - ifun 7–15: 0.
- e_Cnd = cond(e_ifun) only when e_icode is 2 (rrmov/cmov) or 7 (jXX); otherwise 0.
- e_dstE_out = 4'hF when e_icode==2 and e_Cnd==0; otherwise e_dstE.
- set_cc = (e_icode==6) & ~m_exc & ~w_exc & (e_stat==1).
  - When set_cc, CC loads {e_zf,e_sf,e_of} at the clock edge.
  - Otherwise CC holds.
  - CC update is independent of M_bubble/M_stall.
- M register update at each edge, in priority order:
  1. rst.
  2. M_bubble: bubble values as at reset.
  3. M_stall: hold.
  4. Else load {e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE_out, e_dstM}.
- M_bubble and M_stall both high: bubble wins.
- Latency: 1 cycle from execute inputs to M_* outputs.
- e_Cnd and e_dstE_out have 0 latency.
- No internal state besides CC and the M register; no FSM beyond register-update priority.
- All arithmetic is upstream; this block performs no widening or truncation and passes data at WIDTH bits unchanged.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: HALT 0, NOP 1, CMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
  - ifun condition codes 0–6.
  - status codes AOK/HLT/ADR/INS.
  - RNONE=4'hF.
  - bubble constants.
- One sub-module, cond_eval: combinational, inputs ifun and {zf,sf,of}, output cnd. Reused by the fetch-side branch predictor check.

Test Plan:
- Assert rst mid-cycle, no clk edge -> outputs go immediately to CC=100, M_icode=1, M_stat=1, M_dstE=M_dstM=F.
- OPq (icode 6, ifun 1 sub), e_valE=0, e_zf=1, e_sf=0, e_of=0, m_exc=w_exc=0 -> after edge CC=100. Next, jle (7/1) -> e_Cnd=1, M_Cnd=1 one cycle later.
- CC=000, cmovne (2/4), e_dstE=3 -> e_Cnd=1, e_dstE_out=3. Then CC=100, cmovne -> e_Cnd=0, e_dstE_out=F, M_dstE=F.
- OPq with e_sf=1 while m_exc=1 -> CC unchanged (100), and M still loads the OPq with M_valE=e_valE.
- M_bubble=1 with valid mrmovq inputs (e_dstM=5) -> M_icode=1, M_dstM=F. M_bubble=M_stall=1 together -> bubble values. M_stall alone -> all M_* hold for 3 cycles with changing inputs.
- jg (7/6) with CC=010 -> e_Cnd=0. ifun=9 on jXX -> e_Cnd=0. irmovq (3) -> e_Cnd=0, e_dstE_out=e_dstE.
